// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback staging pipe.
package wb_pkg;

  // Default result and register-address widths.
  localparam int WB_DATA_W = 128;
  localparam int WB_ADDR_W = 7;

  // Up to this many execution units can be described by a latency table.
  localparam int WB_MAX_UNITS = 5;
  localparam int WB_LAT_W     = 8;

  // Injection stage per unit; entry u belongs to unit u.
  typedef logic [WB_MAX_UNITS-1:0][WB_LAT_W-1:0] wb_lat_table_t;

  // Units 0..4 inject at stages 7, 6, 4, 4, 2. Only the first NUM_UNITS entries are used.
  localparam wb_lat_table_t WB_DEF_UNIT_LAT = {8'd2, 8'd4, 8'd4, 8'd6, 8'd7};

  // One staging slot. Slots with write == 0 still carry data/addr down the pipe.
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_ADDR_W-1:0] addr;
    logic                 write;
  } wb_entry_t;

  // Collision counter saturates at this value.
  localparam logic [7:0] WB_CNT_MAX = 8'hFF;

  // A unit's injection stage must name a real stage 1..depth.
  function automatic bit lat_in_range(input int unsigned lat, input int unsigned depth);
    return (lat >= 1) && (lat <= depth);
  endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Forwarding lookup for one query port: finds the newest staged write to an address.
module wb_fwd_lookup
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 7
) (
  input  logic [ADDR_W-1:0]             rd_addr_i,
  // Index 0 holds stage 1 (the newest), index DEPTH-1 holds stage DEPTH.
  input  logic [DEPTH-1:0][ADDR_W-1:0]  stg_addr_i,
  input  logic [DEPTH-1:0]              stg_write_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  stg_data_i,
  output logic                          hit_o,
  output logic [DATA_W-1:0]             data_o
);

  // Scan oldest to newest so the newest matching stage is the final assignment.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stg_write_i[k] && (stg_addr_i[k] == rd_addr_i)) begin
        hit_o  = 1'b1;
        data_o = stg_data_i[k];
      end
    end
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback staging pipe. Execution units with different latencies inject
// results at their own stage; everything then shifts one stage per cycle
// until stage DEPTH presents it on the writeback port. Staged writes are
// visible to forwarding queries and to hazard detection.
//
// Handshake: unit_valid_i[u] & unit_write_i[u] in a cycle is one injection
// into stage UNIT_LAT[u]. There is no ready: units never stall, and an
// injection that loses arbitration or overwrites a live write is dropped
// and reported through the collision flag/counter.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int            DATA_W       = WB_DATA_W,
  parameter int            ADDR_W       = WB_ADDR_W,
  parameter int            DEPTH        = 7,
  parameter int            NUM_UNITS    = 4,
  parameter wb_lat_table_t UNIT_LAT     = WB_DEF_UNIT_LAT,
  parameter int            NUM_RD       = 3,
  parameter int            FLUSH_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_UNITS-1:0]              unit_valid_i,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]  unit_data_i,
  input  logic [NUM_UNITS-1:0][ADDR_W-1:0]  unit_addr_i,
  input  logic [NUM_UNITS-1:0]              unit_write_i,
  input  logic                              flush_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]     rd_addr_i,
  output logic [NUM_RD-1:0]                 rd_hit_o,
  output logic [NUM_RD-1:0][DATA_W-1:0]     rd_data_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]      stg_addr_o,
  output logic [DEPTH-1:0]                  stg_write_o,
  output logic [DATA_W-1:0]                 wb_data_o,
  output logic [ADDR_W-1:0]                 wb_addr_o,
  output logic                              wb_write_o,
  output logic                              collision_o,
  output logic [7:0]                        collision_cnt_o
);

  localparam int UIDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "wb_stage_pipe: DEPTH must be at least 1");
  end
  if ((FLUSH_STAGES < 0) || (FLUSH_STAGES > DEPTH)) begin : g_bad_flush
    $fatal(1, "wb_stage_pipe: FLUSH_STAGES must be within 0..DEPTH");
  end
  if ((NUM_UNITS < 1) || (NUM_UNITS > WB_MAX_UNITS)) begin : g_bad_units
    $fatal(1, "wb_stage_pipe: NUM_UNITS must be within 1..WB_MAX_UNITS");
  end
  for (genvar gu = 0; gu < NUM_UNITS; gu++) begin : g_lat_chk
    if (!lat_in_range(UNIT_LAT[gu], DEPTH)) begin : g_bad_lat
      $fatal(1, "wb_stage_pipe: UNIT_LAT entry outside 1..DEPTH");
    end
  end

  // Same field layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              write;
  } entry_t;

  entry_t     stage_q [1:DEPTH];
  entry_t     stage_d [1:DEPTH];
  logic       coll_q, coll_d;
  logic [7:0] cnt_q, cnt_d;
  logic       coll_evt;

  // A unit only claims its stage when it both presents and writes a result.
  logic [NUM_UNITS-1:0] inj_req;
  assign inj_req = unit_valid_i & unit_write_i;

  // Next stage contents: lowest-index injector wins, otherwise shift from the
  // stage above (stage 0 is an all-zero slot). Flush clears the write flag of
  // whatever lands in the young stages, injected or shifted.
  always_comb begin
    entry_t            prev_e;
    int unsigned       n_inj;
    logic [UIDX_W-1:0] win;
    coll_evt = 1'b0;
    prev_e   = '0;
    n_inj    = 0;
    win      = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 1) begin
        prev_e = '0;
      end else begin
        prev_e = stage_q[k-1];
      end
      n_inj = 0;
      win   = '0;
      for (int u = NUM_UNITS - 1; u >= 0; u--) begin
        if (inj_req[u] && (32'(UNIT_LAT[u]) == k)) begin
          n_inj = n_inj + 1;
          win   = UIDX_W'(u);
        end
      end
      stage_d[k] = prev_e;
      if (n_inj != 0) begin
        stage_d[k].data  = unit_data_i[win];
        stage_d[k].addr  = unit_addr_i[win];
        stage_d[k].write = 1'b1;
        // Losing injectors are dropped; a live write from above is overwritten.
        if ((n_inj > 1) || prev_e.write) begin
          coll_evt = 1'b1;
        end
      end
      if (flush_i && (k <= FLUSH_STAGES)) begin
        stage_d[k].write = 1'b0;
      end
    end
  end

  // Sticky flag and saturating count advance once per cycle with any collision.
  always_comb begin
    coll_d = coll_q;
    cnt_d  = cnt_q;
    if (coll_evt) begin
      coll_d = 1'b1;
      if (cnt_q != WB_CNT_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Stage registers and collision state; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      coll_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      stage_q <= stage_d;
      coll_q  <= coll_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flattened stage view for hazard detection and forwarding.
  logic [DEPTH-1:0][DATA_W-1:0] stg_data;
  for (genvar gk = 1; gk <= DEPTH; gk++) begin : g_stg_out
    assign stg_addr_o[gk-1]  = stage_q[gk].addr;
    assign stg_write_o[gk-1] = stage_q[gk].write;
    assign stg_data[gk-1]    = stage_q[gk].data;
  end

  // One lookup per query port; each returns the newest matching staged write.
  for (genvar gr = 0; gr < NUM_RD; gr++) begin : g_fwd
    wb_fwd_lookup #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_lookup (
      .rd_addr_i   (rd_addr_i[gr]),
      .stg_addr_i  (stg_addr_o),
      .stg_write_i (stg_write_o),
      .stg_data_i  (stg_data),
      .hit_o       (rd_hit_o[gr]),
      .data_o      (rd_data_o[gr])
    );
  end

  assign wb_data_o       = stage_q[DEPTH].data;
  assign wb_addr_o       = stage_q[DEPTH].addr;
  assign wb_write_o      = stage_q[DEPTH].write;
  assign collision_o     = coll_q;
  assign collision_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: directed scenarios followed by random traffic,
// compared every cycle against a token-list model of the staging pipe.
module tb_wb_stage_pipe;
  import wb_pkg::*;

  localparam int DW    = 128;
  localparam int AW    = 7;
  localparam int DEPTH = 7;
  localparam int NU    = 5;
  localparam int NRD   = 3;
  localparam int FL    = 2;
  localparam int LAT [NU] = '{7, 6, 4, 4, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NU-1:0]             unit_valid, unit_write;
  logic [NU-1:0][DW-1:0]     unit_data;
  logic [NU-1:0][AW-1:0]     unit_addr;
  logic                      flush;
  logic [NRD-1:0][AW-1:0]    rd_addr;
  logic [NRD-1:0]            rd_hit_o;
  logic [NRD-1:0][DW-1:0]    rd_data_o;
  logic [DEPTH-1:0][AW-1:0]  stg_addr_o;
  logic [DEPTH-1:0]          stg_write_o;
  logic [DW-1:0]             wb_data_o;
  logic [AW-1:0]             wb_addr_o;
  logic                      wb_write_o;
  logic                      collision_o;
  logic [7:0]                collision_cnt_o;

  wb_stage_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_UNITS(NU),
    .NUM_RD(NRD), .FLUSH_STAGES(FL)
  ) dut (
    .clk(clk), .reset(reset),
    .unit_valid_i(unit_valid), .unit_data_i(unit_data),
    .unit_addr_i(unit_addr), .unit_write_i(unit_write),
    .flush_i(flush), .rd_addr_i(rd_addr),
    .rd_hit_o(rd_hit_o), .rd_data_o(rd_data_o),
    .stg_addr_o(stg_addr_o), .stg_write_o(stg_write_o),
    .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o), .wb_write_o(wb_write_o),
    .collision_o(collision_o), .collision_cnt_o(collision_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Each in-flight result is a token at a stage position; empty stages read as zero.
  typedef struct {
    int        pos;
    wb_entry_t e;
  } tok_t;

  tok_t toks[$];
  bit   m_coll;
  int   m_cnt;

  task automatic model_clock();
    tok_t nxt[$];
    tok_t t;
    int   inj_n [DEPTH+1];
    int   inj_u [DEPTH+1];
    bit   evt;
    if (reset) begin
      toks.delete();
      m_coll = 0;
      m_cnt  = 0;
      return;
    end
    for (int k = 0; k <= DEPTH; k++) begin
      inj_n[k] = 0;
      inj_u[k] = -1;
    end
    for (int u = 0; u < NU; u++) begin
      if (unit_valid[u] && unit_write[u]) begin
        if (inj_n[LAT[u]] == 0) inj_u[LAT[u]] = u;
        inj_n[LAT[u]]++;
      end
    end
    evt = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (inj_n[k] > 1) evt = 1;
      if (inj_n[k] > 0) begin
        foreach (toks[i]) if (toks[i].pos == k - 1 && toks[i].e.write) evt = 1;
      end
    end
    foreach (toks[i]) begin
      t = toks[i];
      t.pos++;
      if (t.pos <= DEPTH && inj_n[t.pos] == 0) nxt.push_back(t);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (inj_n[k] > 0) begin
        t.pos     = k;
        t.e.data  = unit_data[inj_u[k]];
        t.e.addr  = unit_addr[inj_u[k]];
        t.e.write = 1'b1;
        nxt.push_back(t);
      end
    end
    if (flush) begin
      foreach (nxt[i]) if (nxt[i].pos <= FL) nxt[i].e.write = 1'b0;
    end
    toks = nxt;
    if (evt) begin
      m_coll = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  function automatic wb_entry_t exp_stage(input int k);
    wb_entry_t r;
    r = '0;
    foreach (toks[i]) if (toks[i].pos == k) r = toks[i].e;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    wb_entry_t     s;
    int            best;
    logic          e_hit;
    logic [DW-1:0] e_data;
    for (int k = 1; k <= DEPTH; k++) begin
      s = exp_stage(k);
      chk($sformatf("stg_addr[%0d]", k), DW'(stg_addr_o[k-1]), DW'(s.addr));
      chk($sformatf("stg_write[%0d]", k), DW'(stg_write_o[k-1]), DW'(s.write));
    end
    s = exp_stage(DEPTH);
    chk("wb_data", wb_data_o, s.data);
    chk("wb_addr", DW'(wb_addr_o), DW'(s.addr));
    chk("wb_write", DW'(wb_write_o), DW'(s.write));
    chk("collision", DW'(collision_o), DW'(m_coll));
    chk("collision_cnt", DW'(collision_cnt_o), DW'(m_cnt));
    for (int r = 0; r < NRD; r++) begin
      best = DEPTH + 1; e_hit = 0; e_data = '0;
      foreach (toks[i]) begin
        if (toks[i].e.write && toks[i].e.addr == rd_addr[r] && toks[i].pos < best) begin
          best = toks[i].pos; e_hit = 1; e_data = toks[i].e.data;
        end
      end
      chk($sformatf("rd_hit[%0d]", r), DW'(rd_hit_o[r]), DW'(e_hit));
      chk($sformatf("rd_data[%0d]", r), rd_data_o[r], e_data);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle();
    unit_valid = '0; unit_write = '0; unit_data = '0; unit_addr = '0; flush = 1'b0;
    for (int i = 0; i < NRD; i++) rd_addr[i] = AW'($urandom_range(0, 15));
  endtask

  task automatic inject(input int u, input logic [AW-1:0] a, input logic [DW-1:0] d);
    unit_valid[u] = 1'b1; unit_write[u] = 1'b1; unit_addr[u] = a; unit_data[u] = d;
  endtask

  // Inputs are set just after a falling edge; check, then clock the model with the DUT.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; idle();
    cycle(); cycle();
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int            n_wb, wb_at;
    bit            seen9;
    logic [DW-1:0] cap_data, d_y;
    logic [AW-1:0] cap_addr;

    reset = 1'b1; idle();
    @(negedge clk); @(posedge clk); model_clock(); @(negedge clk);
    // Reset state with arbitrary query addresses.
    do_reset();
    rd_addr[0] = 7'd0; rd_addr[1] = 7'd5; rd_addr[2] = 7'd127;
    #1;
    chk("post-reset rd_hit", DW'(rd_hit_o), '0);
    chk("post-reset wb_write", DW'(wb_write_o), '0);

    // Single result from the shortest-latency unit.
    do_reset();
    idle(); inject(4, 7'd5, 128'hA5); cycle();
    n_wb = 0; wb_at = -1; cap_data = '0; cap_addr = '0;
    for (int c = 1; c <= 10; c++) begin
      if (wb_write_o) begin n_wb++; wb_at = c; cap_data = wb_data_o; cap_addr = wb_addr_o; end
      idle(); cycle();
    end
    chk("lat2 wb pulses", DW'(n_wb), 1);
    chk("lat2 wb cycle", DW'(wb_at), 6);
    chk("lat2 wb data", cap_data, 128'hA5);
    chk("lat2 wb addr", DW'(cap_addr), 5);

    // Two units contend for stage 4; unit 2 wins.
    do_reset();
    idle(); inject(2, 7'd10, 128'hD2); inject(3, 7'd11, 128'hD3); cycle();
    n_wb = 0; wb_at = -1; cap_data = '0;
    for (int c = 1; c <= 8; c++) begin
      if (wb_write_o) begin n_wb++; wb_at = c; cap_data = wb_data_o; end
      idle(); cycle();
    end
    chk("contend wb pulses", DW'(n_wb), 1);
    chk("contend wb cycle", DW'(wb_at), 4);
    chk("contend wb data", cap_data, 128'hD2);
    chk("contend collision", DW'(collision_o), 1);
    chk("contend cnt", DW'(collision_cnt_o), 1);

    // Injection into stage 4 overwrites a live write coming from stage 3.
    do_reset();
    idle(); inject(4, 7'd9, 128'h99); cycle();
    idle(); cycle();
    idle(); inject(2, 7'd12, 128'h12); cycle();
    seen9 = 0;
    for (int c = 0; c < 10; c++) begin
      if (wb_write_o && wb_addr_o == 7'd9) seen9 = 1;
      idle(); cycle();
    end
    chk("overwrite addr9 seen", DW'(seen9), 0);
    chk("overwrite cnt", DW'(collision_cnt_o), 1);

    // Two staged writes to addr 3 at stages 5 and 2; the newer one forwards.
    do_reset();
    d_y = rnd_data();
    idle(); inject(4, 7'd3, rnd_data()); cycle();
    idle(); cycle();
    idle(); cycle();
    idle(); inject(4, 7'd3, d_y); cycle();
    idle(); rd_addr[0] = 7'd3; rd_addr[2] = 7'd100;
    #1;
    chk("fwd stage5 write", DW'(stg_write_o[4]), 1);
    chk("fwd stage5 addr", DW'(stg_addr_o[4]), 3);
    chk("fwd rd_hit0", DW'(rd_hit_o[0]), 1);
    chk("fwd rd_data0", rd_data_o[0], d_y);
    chk("fwd rd_hit2", DW'(rd_hit_o[2]), 0);
    chk("fwd rd_data2", rd_data_o[2], '0);
    cycle();

    // Flush one cycle after injection: the entry has moved past the young stages.
    do_reset();
    idle(); inject(4, 7'd7, 128'h77); cycle();
    idle(); flush = 1'b1; cycle();
    idle(); #1;
    chk("late flush stage3 write", DW'(stg_write_o[2]), 1);
    chk("late flush stage3 addr", DW'(stg_addr_o[2]), 7);
    n_wb = 0;
    for (int c = 0; c < 8; c++) begin
      if (wb_write_o) n_wb++;
      idle(); cycle();
    end
    chk("late flush wb pulses", DW'(n_wb), 1);

    // Flush alongside injection into stage 2 kills it.
    do_reset();
    idle(); inject(4, 7'd7, 128'h77); flush = 1'b1; cycle();
    idle(); #1;
    chk("same flush stage2 write", DW'(stg_write_o[1]), 0);
    chk("same flush stage2 addr", DW'(stg_addr_o[1]), 7);
    n_wb = 0;
    for (int c = 0; c < 8; c++) begin
      if (wb_write_o) n_wb++;
      idle(); cycle();
    end
    chk("same flush wb pulses", DW'(n_wb), 0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      idle();
      for (int u = 0; u < NU; u++) begin
        if ($urandom_range(0, 2) == 0) begin
          unit_valid[u] = 1'b1;
          unit_write[u] = ($urandom_range(0, 3) != 0);
          unit_addr[u]  = AW'($urandom_range(0, 15));
          unit_data[u]  = rnd_data();
        end
      end
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;

    // Saturate the collision counter, fill the pipe, then reset mid-stream.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      idle(); inject(2, 7'd20, rnd_data()); inject(3, 7'd21, rnd_data()); cycle();
    end
    idle(); #1;
    chk("sat cnt", DW'(collision_cnt_o), 255);
    chk("sat collision", DW'(collision_o), 1);
    inject(0, 7'd30, rnd_data()); inject(1, 7'd31, rnd_data()); inject(4, 7'd32, rnd_data());
    cycle();
    idle(); inject(4, 7'd33, rnd_data()); cycle();
    idle(); reset = 1'b1; inject(4, 7'd34, rnd_data()); flush = 1'b1; cycle();
    reset = 1'b0; idle();
    rd_addr[0] = 7'd32; rd_addr[1] = 7'd33; rd_addr[2] = 7'd30;
    #1;
    chk("mid reset wb_write", DW'(wb_write_o), 0);
    chk("mid reset wb_data", wb_data_o, '0);
    chk("mid reset wb_addr", DW'(wb_addr_o), 0);
    chk("mid reset stg_write", DW'(stg_write_o), 0);
    chk("mid reset stg_addr", DW'(stg_addr_o), 0);
    chk("mid reset collision", DW'(collision_o), 0);
    chk("mid reset cnt", DW'(collision_cnt_o), 0);
    chk("mid reset rd_hit", DW'(rd_hit_o), 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
